// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM: Moore state register plus decoded datapath controls.
// Write enables and memreq are forced low combinationally while reset is asserted.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       memreq,
  output logic       pcEn,
  output logic       IorD,
  output logic       memwrite,
  output logic       IRwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrcA,
  output logic [1:0] alusrcB,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBeq     = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  state_e state_q, state_d;

  logic pcwrite, branch;
  logic memreq_raw, memwrite_raw, irwrite_raw, regwrite_raw, illegal_raw;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    memreq_raw   = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    IorD         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrcA      = 1'b0;
    alusrcB      = 2'b00;
    pcsrc        = 2'b00;
    alucontrol   = 3'b000;
    case (state_q)
      StFetch: begin
        memreq_raw  = 1'b1;
        alusrcB     = 2'b01;
        alucontrol  = 3'b010;
        irwrite_raw = memready;
        pcwrite     = memready;
        state_d     = memready ? StDecode : StFetch;
      end
      StDecode: begin
        alusrcB    = 2'b11;
        alucontrol = 3'b010;
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBeq;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            state_d     = StFetch;
            illegal_raw = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alusrcA    = 1'b1;
        alusrcB    = 2'b10;
        alucontrol = 3'b010;
        state_d    = (op == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        memreq_raw = 1'b1;
        IorD       = 1'b1;
        if (memready) state_d = StMemWb;
      end
      StMemWb: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
        state_d      = StFetch;
      end
      StMemWr: begin
        memreq_raw   = 1'b1;
        IorD         = 1'b1;
        memwrite_raw = 1'b1;
        if (memready) state_d = StFetch;
      end
      StExecute: begin
        alusrcA = 1'b1;
        state_d = StAluWb;
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default: begin
            alucontrol  = 3'b010;
            illegal_raw = 1'b1;
          end
        endcase
      end
      StAluWb: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
        state_d      = StFetch;
      end
      StBeq: begin
        alusrcA    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        state_d    = StFetch;
      end
      StAddiEx: begin
        alusrcA    = 1'b1;
        alusrcB    = 2'b10;
        alucontrol = 3'b010;
        state_d    = StAddiWb;
      end
      StAddiWb: begin
        regwrite_raw = 1'b1;
        state_d      = StFetch;
      end
      StJump: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = StFetch;
      end
      // Unused encodings 12-15 recover to FETCH.
      default: state_d = StFetch;
    endcase
  end

  assign pcEn     = reset & (pcwrite | (branch & zero));
  assign memreq   = reset & memreq_raw;
  assign memwrite = reset & memwrite_raw;
  assign IRwrite  = reset & irwrite_raw;
  assign regwrite = reset & regwrite_raw;
  assign illegal  = reset & illegal_raw;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected state/controls are queued with
// their stimulus, then replayed and compared at the falling edge.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, memready;
  logic       memreq, pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite, alusrcA;
  logic [1:0] alusrcB, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       illegal;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        mr;
    logic        rs;
  } ent_t;

  ent_t sb[$];
  ent_t e;

  logic [16:0] act;
  assign act = {memreq, pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite, alusrcA,
                alusrcB, pcsrc, alucontrol, illegal};

  mc_controller dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .memready  (memready),
    .memreq    (memreq),
    .pcEn      (pcEn),
    .IorD      (IorD),
    .memwrite  (memwrite),
    .IRwrite   (IRwrite),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .alusrcA   (alusrcA),
    .alusrcB   (alusrcB),
    .pcsrc     (pcsrc),
    .alucontrol(alucontrol),
    .state     (state),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Expected control word for a state, straight from the state table.
  function automatic logic [16:0] exp_ctl(input logic [3:0] s, input logic [5:0] o,
                                          input logic [5:0] f, input logic z, input logic mr,
                                          input logic rs);
    logic mq, pe, iod, mw, irw, rd, m2r, rw, sa, il;
    logic [1:0] sb_sel, ps;
    logic [2:0] ac;
    {mq, pe, iod, mw, irw, rd, m2r, rw, sa, il} = '0;
    sb_sel = 2'b00; ps = 2'b00; ac = 3'b000;
    case (s)
      4'd0:  begin mq = 1; sb_sel = 2'b01; ac = 3'b010; irw = mr; pe = mr; end
      4'd1:  begin
        sb_sel = 2'b11; ac = 3'b010;
        il = !(o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
      end
      4'd2:  begin sa = 1; sb_sel = 2'b10; ac = 3'b010; end
      4'd3:  begin mq = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mq = 1; iod = 1; mw = 1; end
      4'd6:  begin
        sa = 1;
        case (f)
          6'b100000: ac = 3'b010;
          6'b100010: ac = 3'b110;
          6'b100100: ac = 3'b000;
          6'b100101: ac = 3'b001;
          6'b101010: ac = 3'b111;
          default:   begin ac = 3'b010; il = 1; end
        endcase
      end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
      4'd9:  begin sa = 1; sb_sel = 2'b10; ac = 3'b010; end
      4'd10: begin rw = 1; end
      4'd11: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    if (!rs) {mq, pe, mw, irw, rw, il} = '0;
    return {mq, pe, iod, mw, irw, rd, m2r, rw, sa, sb_sel, ps, ac, il};
  endfunction

  task automatic push(input logic [3:0] s, input logic mr, input logic rs);
    ent_t n;
    n.st  = s;
    n.mr  = mr;
    n.rs  = rs;
    n.ctl = exp_ctl(s, op, funct, zero, mr, rs);
    sb.push_back(n);
  endtask

  task automatic test_reset();
    reset = 1'b0; memready = 1'b1; op = 6'b000000; funct = 6'b100000; zero = 1'b0;
    @(posedge clk); #1;
    push(4'd0, 1'b1, 1'b0);
    push(4'd0, 1'b1, 1'b0);
    push(4'd0, 1'b0, 1'b1);
    push(4'd0, 1'b0, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      memready = e.mr; reset = e.rs;
      @(negedge clk);
      total++;
      if (state !== e.st || act !== e.ctl)
        $display("FAIL reset: state=%0d ctl=%h, required state=%0d ctl=%h",
                 state, act, e.st, e.ctl);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    op = 6'b100011;
    push(4'd0, 1'b1, 1'b1); push(4'd1, 1'b1, 1'b1); push(4'd2, 1'b1, 1'b1);
    push(4'd3, 1'b1, 1'b1); push(4'd4, 1'b1, 1'b1);
    // Second load with a two-cycle read stall.
    push(4'd0, 1'b1, 1'b1); push(4'd1, 1'b1, 1'b1); push(4'd2, 1'b1, 1'b1);
    push(4'd3, 1'b0, 1'b1); push(4'd3, 1'b0, 1'b1); push(4'd3, 1'b1, 1'b1);
    push(4'd4, 1'b1, 1'b1); push(4'd0, 1'b0, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      memready = e.mr; reset = e.rs;
      @(negedge clk);
      total++;
      if (state !== e.st || act !== e.ctl)
        $display("FAIL lw: state=%0d ctl=%h, required state=%0d ctl=%h",
                 state, act, e.st, e.ctl);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_stall();
    op = 6'b101011;
    push(4'd0, 1'b1, 1'b1); push(4'd1, 1'b1, 1'b1); push(4'd2, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) push(4'd5, 1'b0, 1'b1);
    push(4'd5, 1'b1, 1'b1); push(4'd0, 1'b0, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      memready = e.mr; reset = e.rs;
      @(negedge clk);
      total++;
      if (state !== e.st || act !== e.ctl)
        $display("FAIL sw_stall: state=%0d ctl=%h, required state=%0d ctl=%h",
                 state, act, e.st, e.ctl);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fl [6];
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    op = 6'b000000;
    for (int k = 0; k < 6; k++) begin
      funct = fl[k];
      push(4'd0, 1'b1, 1'b1); push(4'd1, 1'b1, 1'b1);
      push(4'd6, 1'b1, 1'b1); push(4'd7, 1'b1, 1'b1);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        memready = e.mr; reset = e.rs;
        @(negedge clk);
        total++;
        if (state !== e.st || act !== e.ctl)
          $display("FAIL rtype funct=%b: state=%0d ctl=%h, required state=%0d ctl=%h",
                   funct, state, act, e.st, e.ctl);
        else passed++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_beq();
    op = 6'b000100;
    for (int k = 0; k < 2; k++) begin
      zero = (k == 0);
      push(4'd0, 1'b1, 1'b1); push(4'd1, 1'b1, 1'b1); push(4'd8, 1'b1, 1'b1);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        memready = e.mr; reset = e.rs;
        @(negedge clk);
        total++;
        if (state !== e.st || act !== e.ctl)
          $display("FAIL beq zero=%b: state=%0d ctl=%h, required state=%0d ctl=%h",
                   zero, state, act, e.st, e.ctl);
        else passed++;
        @(posedge clk); #1;
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_addi_jump();
    op = 6'b001000;
    push(4'd0, 1'b1, 1'b1); push(4'd1, 1'b1, 1'b1);
    push(4'd9, 1'b1, 1'b1); push(4'd10, 1'b1, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      memready = e.mr; reset = e.rs;
      @(negedge clk);
      total++;
      if (state !== e.st || act !== e.ctl)
        $display("FAIL addi: state=%0d ctl=%h, required state=%0d ctl=%h",
                 state, act, e.st, e.ctl);
      else passed++;
      @(posedge clk); #1;
    end
    op = 6'b000010;
    push(4'd0, 1'b1, 1'b1); push(4'd1, 1'b1, 1'b1); push(4'd11, 1'b1, 1'b1);
    push(4'd0, 1'b0, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      memready = e.mr; reset = e.rs;
      @(negedge clk);
      total++;
      if (state !== e.st || act !== e.ctl)
        $display("FAIL jump: state=%0d ctl=%h, required state=%0d ctl=%h",
                 state, act, e.st, e.ctl);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    op = 6'b111111;
    push(4'd0, 1'b1, 1'b1); push(4'd1, 1'b1, 1'b1); push(4'd0, 1'b0, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      memready = e.mr; reset = e.rs;
      @(negedge clk);
      total++;
      if (state !== e.st || act !== e.ctl)
        $display("FAIL illegal_op: state=%0d ctl=%h, required state=%0d ctl=%h",
                 state, act, e.st, e.ctl);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midway();
    // Abort a stalled read, then a stalled write.
    op = 6'b100011;
    push(4'd0, 1'b1, 1'b1); push(4'd1, 1'b1, 1'b1); push(4'd2, 1'b1, 1'b1);
    push(4'd3, 1'b0, 1'b1); push(4'd3, 1'b0, 1'b0); push(4'd0, 1'b1, 1'b0);
    push(4'd0, 1'b0, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      memready = e.mr; reset = e.rs;
      @(negedge clk);
      total++;
      if (state !== e.st || act !== e.ctl)
        $display("FAIL reset_memrd: state=%0d ctl=%h, required state=%0d ctl=%h",
                 state, act, e.st, e.ctl);
      else passed++;
      @(posedge clk); #1;
    end
    op = 6'b101011;
    push(4'd0, 1'b1, 1'b1); push(4'd1, 1'b1, 1'b1); push(4'd2, 1'b1, 1'b1);
    push(4'd5, 1'b0, 1'b1); push(4'd5, 1'b1, 1'b0); push(4'd0, 1'b1, 1'b1);
    push(4'd1, 1'b1, 1'b1); push(4'd2, 1'b1, 1'b1); push(4'd5, 1'b1, 1'b1);
    push(4'd0, 1'b0, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      memready = e.mr; reset = e.rs;
      @(negedge clk);
      total++;
      if (state !== e.st || act !== e.ctl)
        $display("FAIL reset_memwr: state=%0d ctl=%h, required state=%0d ctl=%h",
                 state, act, e.st, e.ctl);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b0; memready = 1'b0; op = '0; funct = '0; zero = 1'b0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype();
    test_beq();
    test_addi_jump();
    test_illegal();
    test_reset_midway();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none; all encodings are fixed by this document.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-low; reset=0 sampled at a rising edge returns the block to FETCH.
REQ-004 op  in  6  instruction bits [31:26], taken from the datapath instruction register output.
REQ-005 funct  in  6  instruction bits [5:0], taken from the same output.
REQ-006 zero  in  1  ALU zero flag from the datapath.
REQ-007 memready  in  1  memory completion for the current access.
REQ-008 memreq  out  1  memory access request.
REQ-009 pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite, alusrcA  out  1 each  datapath controls.
REQ-010 alusrcB, pcsrc  out  2 each  datapath mux selects.
REQ-011 alucontrol  out  3  ALU operation.
REQ-012 state  out  4  current state encoding, for debug.
REQ-013 illegal  out  1  one-cycle pulse on an undecodable instruction.

Function
REQ-014 Moore FSM, registered 4-bit state with these encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- EXECUTE=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11
- Encodings 12-15 go to FETCH on the next edge.
REQ-015 Controls not listed for a state are 0.
REQ-016 Mux selects:
- alusrcA: 0=pc, 1=regA.
- alusrcB: 00=regB, 01=4, 10=signimm, 11=signimm<<2.
- pcsrc: 00=ALU result, 01=registered ALU result, 10=jump target.
REQ-017 FETCH:
- memreq=1, IorD=0, alusrcA=0, alusrcB=01, alucontrol=010.
- IRwrite=pcEn=memready.
- Stay in FETCH while memready=0; go to DECODE when memready=1.
REQ-018 DECODE: alusrcA=0, alusrcB=11, alucontrol=010. Next state by op:
- 100011 or 101011 -> MEMADR.
- 000000 -> EXECUTE.
- 000100 -> BEQ.
- 001000 -> ADDIEX.
- 000010 -> JUMP.
- any other op -> FETCH, with illegal=1 for that cycle.
REQ-019 MEMADR: alusrcA=1, alusrcB=10, alucontrol=010; next is MEMRD if op=100011, else MEMWR.
REQ-020 MEMRD: memreq=1, IorD=1; stay while memready=0, then go to MEMWB.
REQ-021 MEMWB: regwrite=1, regdst=0, memtoreg=1; next FETCH.
REQ-022 MEMWR: memreq=1, IorD=1, memwrite=1 held until memready=1; next FETCH.
REQ-023 EXECUTE: alusrcA=1, alusrcB=00, alucontrol per REQ-024; next ALUWB.
REQ-024 funct decode for alucontrol:
- 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
- Any other funct -> 010 with illegal=1 in EXECUTE; ALUWB still follows.
REQ-025 ALUWB: regwrite=1, regdst=1, memtoreg=0; next FETCH.
REQ-026 BEQ:
- alusrcA=1, alusrcB=00, alucontrol=110, pcsrc=01.
- pcEn=zero.
- Next FETCH.
REQ-027 ADDIEX: alusrcA=1, alusrcB=10, alucontrol=010; next ADDIWB.
REQ-028 ADDIWB: regwrite=1, regdst=0, memtoreg=0; next FETCH.
REQ-029 JUMP: pcsrc=10, pcEn=1; next FETCH.
REQ-030 pcEn is combinational: pcwrite OR (branch AND zero).
REQ-031 Cycle counts with memready tied 1:
- lw = 5, sw = 4, R-type = 4, addi = 4, beq = 3, j = 3.
- Each cycle memready=0 in a memory-access state adds 1 cycle.
REQ-032 memwrite, regwrite, IRwrite and pcEn are never asserted in the same cycle as each other, except IRwrite with pcEn in FETCH.

Reset
REQ-033 While reset=0, the following are forced 0 combinationally: pcEn, memwrite, IRwrite, regwrite, memreq, illegal.
REQ-034 The first edge with reset=0 loads state=0 (FETCH).
REQ-035 Reset asserted mid-instruction, including during a stalled MEMWR, aborts the instruction; no write occurs after reset is sampled.
REQ-036 After reset is released, the first cycle is FETCH with memreq=1.

Verification
REQ-037 Reset, then lw (op=100011), memready=1 -> state sequence 0,1,2,3,4,0; regwrite=1 only in state 4, with memtoreg=1 and regdst=0.
REQ-038 sw with memready=0 for 3 cycles in MEMWR -> memwrite=1 for exactly 4 cycles, then state 0.
REQ-039 beq with zero=1 -> pcEn=1 in state 8, pcsrc=01; repeat with zero=0 -> pcEn=0 in state 8.
REQ-040 R-type, funct=101010 -> alucontrol=111 in state 6; then state 7 with regdst=1 and regwrite=1.
REQ-041 op=111111 -> illegal=1 for one cycle in state 1, then state 0; no write enable asserted.
REQ-042 reset=0 during MEMRD stall -> next state 0; all enables 0 while reset=0; FETCH resumes after release.
